cp0_reg: RTL and testbench
==========================

CP0_REG -- requirements
Module: cp0_reg

Interface
REQ-001 SHALL have parameter PRID_VAL, default 32'h004C0102, value returned for PRId (reg 15).
REQ-002 SHALL have parameter CONFIG_VAL, default 32'h00008000, reset value of Config (reg 16); BE=1, big-endian.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port we_i  in  1  CP0 write enable, from the wb_cp0_reg_we output of the MEM/WB register.
REQ-006 SHALL have port waddr_i  in  5  CP0 write register number.
REQ-007 SHALL have port data_i  in  32  CP0 write data.
REQ-008 SHALL have port raddr_i  in  5  CP0 read register number, from EX.
REQ-009 SHALL have port int_i  in  6  external hardware interrupt lines.
REQ-010 SHALL have port excepttype_i  in  32  exception code from MEM-stage exception detection.
REQ-011 SHALL have port current_inst_addr_i  in  32  PC of the excepting instruction.
REQ-012 SHALL have port is_in_delayslot_i  in  1  excepting instruction is in a delay slot.
REQ-013 SHALL have port data_o  out  32  read data for raddr_i.
REQ-014 SHALL have ports count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  out  32 each  live register values.
REQ-015 SHALL have port timer_int_o  out  1  timer interrupt request.

Function
REQ-016 SHALL map Count=9, Compare=11, Status=12, Cause=13, EPC=14, PRId=15, Config=16.
REQ-017 SHALL increment Count by 1 every non-reset cycle and wrap from 32'hFFFFFFFF to 0.
REQ-018 SHALL give a same-cycle Count write priority over the increment; the next value is data_i.
REQ-019 SHALL set timer_int_o one cycle after a cycle in which Compare != 0 and Count == Compare.
REQ-020 SHALL hold timer_int_o at 1 until a write to Compare; that write clears it on the same edge.
REQ-021 SHALL load Cause[15:10] from int_i every cycle, giving one cycle of latency.
REQ-022 SHALL restrict Cause writes to bits [9:8] (IP1..0), [23] (IV) and [22] (WP); all other Cause bits are unaffected.
REQ-023 SHALL accept full 32-bit writes to Status, EPC and Compare; writes to PRId, Config and unmapped numbers are ignored.
REQ-024 SHALL, for excepttype_i = 32'h1 (int), 32'h8 (syscall), 32'ha (RI), 32'hd (trap) or 32'hc (ov), apply the following on the same edge:
  - Status[1] (EXL) <= 1.
  - Cause[6:2] <= 0, 8, 10, 13 or 12 respectively.
  - If is_in_delayslot_i = 1: EPC <= current_inst_addr_i - 4 and Cause[31] (BD) <= 1.
  - Otherwise: EPC <= current_inst_addr_i and BD <= 0.
  - If EXL was already 1, EPC and BD SHALL be left unchanged; Status and ExcCode still update.
REQ-025 SHALL, for excepttype_i = 32'he (eret), clear Status[1] and change nothing else.
REQ-026 SHALL ignore all other excepttype_i values.
REQ-027 SHALL resolve a same-edge write and exception on the same field in favour of the exception; non-overlapping fields SHALL take both updates.
REQ-028 SHALL drive data_o combinationally from current register state (no bypass), and SHALL return 0 for unmapped raddr_i.
REQ-029 SHALL drive every *_o register output directly from its flop; prid_o = PRID_VAL constant.

Reset
REQ-030 SHALL, on rst = 1 at a clock edge, set:
  - Count, Compare, Cause, EPC = 0.
  - Status = 32'h10000000 (CU0 = 1).
  - Config = CONFIG_VAL.
  - timer_int_o = 0.
REQ-031 SHALL let rst override any same-cycle write, exception or increment.

Structure
REQ-032 SHALL take the following from the shared defines file, not local literals:
  - CP0 register numbers.
  - Exception-type codes.
  - ExcCode values.
  - RegBus width.
  - RstEnable.
  - WriteEnable.
REQ-033 SHALL be a single flat module with no sub-modules.

Verification
REQ-034 SHALL cover: write Compare=5 after reset -> timer_int_o=1 on the edge after Count reaches 5; write Compare=9 -> timer_int_o=0 next cycle.
REQ-035 SHALL cover: write Count=32'hFFFFFFFE -> count_o reads FFFFFFFE, FFFFFFFF, 0 on successive cycles.
REQ-036 SHALL cover: excepttype 32'h8, PC=32'h100, delay slot=1 -> EPC=32'hFC, BD=1, EXL=1, ExcCode=8; then 32'he -> EXL=0, EPC unchanged.
REQ-037 SHALL cover: write Cause=32'hFFFFFFFF -> cause_o=32'h00C00300 with int_i=0.
REQ-038 SHALL cover: write EPC=32'h40 and excepttype 32'hc at PC=32'h200 in the same cycle -> EPC=32'h200, ExcCode=12.
REQ-039 SHALL cover: rst asserted mid-count with pending timer_int_o -> all outputs reach reset values on that edge; Status=32'h10000000.

Source files
------------

// File: rtl/cp0_reg_pkg.sv
// Shared CP0 defines: bus width, control levels, register numbers,
// exception-type codes and ExcCode values.
package cp0_reg_pkg;

  localparam int unsigned RegBusW = 32;

  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;

  // CP0 register numbers
  localparam logic [4:0] Cp0RegCount   = 5'd9;
  localparam logic [4:0] Cp0RegCompare = 5'd11;
  localparam logic [4:0] Cp0RegStatus  = 5'd12;
  localparam logic [4:0] Cp0RegCause   = 5'd13;
  localparam logic [4:0] Cp0RegEpc     = 5'd14;
  localparam logic [4:0] Cp0RegPrid    = 5'd15;
  localparam logic [4:0] Cp0RegConfig  = 5'd16;

  // Exception-type codes delivered by the MEM stage
  localparam logic [RegBusW-1:0] ExcTypeInt     = 32'h0000_0001;
  localparam logic [RegBusW-1:0] ExcTypeSyscall = 32'h0000_0008;
  localparam logic [RegBusW-1:0] ExcTypeInst    = 32'h0000_000a;
  localparam logic [RegBusW-1:0] ExcTypeTrap    = 32'h0000_000d;
  localparam logic [RegBusW-1:0] ExcTypeOv      = 32'h0000_000c;
  localparam logic [RegBusW-1:0] ExcTypeEret    = 32'h0000_000e;

  // Cause.ExcCode values
  localparam logic [4:0] ExcCodeInt  = 5'd0;
  localparam logic [4:0] ExcCodeSys  = 5'd8;
  localparam logic [4:0] ExcCodeRi   = 5'd10;
  localparam logic [4:0] ExcCodeOv   = 5'd12;
  localparam logic [4:0] ExcCodeTrap = 5'd13;

  // Status reset value: CU0 set, everything else clear
  localparam logic [RegBusW-1:0] StatusRstVal = 32'h1000_0000;

  // Status / Cause bit positions
  localparam int unsigned StatusExlBit = 1;
  localparam int unsigned CauseBdBit   = 31;

endpackage

// File: rtl/cp0_reg.sv
// MIPS coprocessor-0 register file: Count/Compare timer, Status, Cause, EPC,
// PRId and Config, with exception entry and eret handling.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [31:0] PRID_VAL   = 32'h004C_0102,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [4:0]          waddr_i,
  input  logic [RegBusW-1:0]  data_i,
  input  logic [4:0]          raddr_i,
  input  logic [5:0]          int_i,
  input  logic [RegBusW-1:0]  excepttype_i,
  input  logic [RegBusW-1:0]  current_inst_addr_i,
  input  logic                is_in_delayslot_i,
  output logic [RegBusW-1:0]  data_o,
  output logic [RegBusW-1:0]  count_o,
  output logic [RegBusW-1:0]  compare_o,
  output logic [RegBusW-1:0]  status_o,
  output logic [RegBusW-1:0]  cause_o,
  output logic [RegBusW-1:0]  epc_o,
  output logic [RegBusW-1:0]  config_o,
  output logic [RegBusW-1:0]  prid_o,
  output logic                timer_int_o
);

  logic [RegBusW-1:0] count_q, count_d;
  logic [RegBusW-1:0] compare_q, compare_d;
  logic [RegBusW-1:0] status_q, status_d;
  logic [RegBusW-1:0] cause_q, cause_d;
  logic [RegBusW-1:0] epc_q, epc_d;
  logic [RegBusW-1:0] config_q, config_d;
  logic               timer_int_q, timer_int_d;

  logic       wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic       exc_take;
  logic       exc_eret;
  logic [4:0] exc_code;

  assign wr_count   = (we_i == WriteEnable) && (waddr_i == Cp0RegCount);
  assign wr_compare = (we_i == WriteEnable) && (waddr_i == Cp0RegCompare);
  assign wr_status  = (we_i == WriteEnable) && (waddr_i == Cp0RegStatus);
  assign wr_cause   = (we_i == WriteEnable) && (waddr_i == Cp0RegCause);
  assign wr_epc     = (we_i == WriteEnable) && (waddr_i == Cp0RegEpc);

  // Decode the exception type into "take exception" / "eret" and its ExcCode
  always_comb begin
    exc_take = 1'b0;
    exc_eret = 1'b0;
    exc_code = ExcCodeInt;
    case (excepttype_i)
      ExcTypeInt:     begin exc_take = 1'b1; exc_code = ExcCodeInt;  end
      ExcTypeSyscall: begin exc_take = 1'b1; exc_code = ExcCodeSys;  end
      ExcTypeInst:    begin exc_take = 1'b1; exc_code = ExcCodeRi;   end
      ExcTypeTrap:    begin exc_take = 1'b1; exc_code = ExcCodeTrap; end
      ExcTypeOv:      begin exc_take = 1'b1; exc_code = ExcCodeOv;   end
      ExcTypeEret:    exc_eret = 1'b1;
      default:        ;
    endcase
  end

  // Count increments every cycle; a software write takes priority
  always_comb begin
    count_d = count_q + 32'd1;
    if (wr_count) begin
      count_d = data_i;
    end
  end

  // Compare and timer interrupt; a Compare write clears a pending interrupt
  always_comb begin
    compare_d   = compare_q;
    timer_int_d = timer_int_q;
    if ((compare_q != '0) && (count_q == compare_q)) begin
      timer_int_d = 1'b1;
    end
    if (wr_compare) begin
      compare_d   = data_i;
      timer_int_d = 1'b0;
    end
  end

  // Status: software write first, exception/eret override the EXL bit
  always_comb begin
    status_d = status_q;
    if (wr_status) begin
      status_d = data_i;
    end
    if (exc_take) begin
      status_d[StatusExlBit] = 1'b1;
    end else if (exc_eret) begin
      status_d[StatusExlBit] = 1'b0;
    end
  end

  // Cause: IP7..2 sampled each cycle; only IV, WP and IP1..0 are writable;
  // exceptions override ExcCode and (outside EXL) BD
  always_comb begin
    cause_d        = cause_q;
    cause_d[15:10] = int_i;
    if (wr_cause) begin
      cause_d[23:22] = data_i[23:22];
      cause_d[9:8]   = data_i[9:8];
    end
    if (exc_take) begin
      cause_d[6:2] = exc_code;
      if (!status_q[StatusExlBit]) begin
        cause_d[CauseBdBit] = is_in_delayslot_i;
      end
    end
  end

  // EPC: exception entry outside EXL wins over a same-cycle write
  always_comb begin
    epc_d = epc_q;
    if (wr_epc) begin
      epc_d = data_i;
    end
    if (exc_take && !status_q[StatusExlBit]) begin
      epc_d = is_in_delayslot_i ? (current_inst_addr_i - 32'd4) : current_inst_addr_i;
    end
  end

  // Config is read-only after reset
  always_comb begin
    config_d = config_q;
  end

  // State registers with synchronous reset overriding every other update
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      count_q     <= '0;
      compare_q   <= '0;
      status_q    <= StatusRstVal;
      cause_q     <= '0;
      epc_q       <= '0;
      config_q    <= CONFIG_VAL;
      timer_int_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      compare_q   <= compare_d;
      status_q    <= status_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      config_q    <= config_d;
      timer_int_q <= timer_int_d;
    end
  end

  // Read port: current state only, zero for unmapped numbers
  always_comb begin
    data_o = '0;
    case (raddr_i)
      Cp0RegCount:   data_o = count_q;
      Cp0RegCompare: data_o = compare_q;
      Cp0RegStatus:  data_o = status_q;
      Cp0RegCause:   data_o = cause_q;
      Cp0RegEpc:     data_o = epc_q;
      Cp0RegPrid:    data_o = PRID_VAL;
      Cp0RegConfig:  data_o = config_q;
      default:       data_o = '0;
    endcase
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign config_o    = config_q;
  assign prid_o      = PRID_VAL;
  assign timer_int_o = timer_int_q;

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg: vector table for register accesses and
// exceptions, plus hand sequences for timer, Count wrap and reset.
module tb_cp0_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
  logic        timer_int_o;

  int n_total = 0;
  int n_pass  = 0;

  cp0_reg dut (
    .clk                 (clk),
    .rst                 (rst),
    .we_i                (we_i),
    .waddr_i             (waddr_i),
    .data_i              (data_i),
    .raddr_i             (raddr_i),
    .int_i               (int_i),
    .excepttype_i        (excepttype_i),
    .current_inst_addr_i (current_inst_addr_i),
    .is_in_delayslot_i   (is_in_delayslot_i),
    .data_o              (data_o),
    .count_o             (count_o),
    .compare_o           (compare_o),
    .status_o            (status_o),
    .cause_o             (cause_o),
    .epc_o               (epc_o),
    .config_o            (config_o),
    .prid_o              (prid_o),
    .timer_int_o         (timer_int_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exc;
    logic [31:0] pc;
    logic        ds;
    logic [5:0]  intr;
    logic [31:0] exp;
  } vec_t;

  localparam int NVec = 22;
  vec_t vecs [NVec];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    we_i = 1'b0; waddr_i = '0; data_i = '0; raddr_i = '0; int_i = '0;
    excepttype_i = '0; current_inst_addr_i = '0; is_in_delayslot_i = 1'b0;
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"},   count_o,   32'h0);
    check({tag, "_compare"}, compare_o, 32'h0);
    check({tag, "_status"},  status_o,  32'h1000_0000);
    check({tag, "_cause"},   cause_o,   32'h0);
    check({tag, "_epc"},     epc_o,     32'h0);
    check({tag, "_config"},  config_o,  32'h0000_8000);
    check({tag, "_prid"},    prid_o,    32'h004C_0102);
    check({tag, "_timer"},   {31'b0, timer_int_o}, 32'h0);
  endtask

  initial begin
    bit found;
    idle_inputs();

    //            we   waddr  wdata          raddr  exc    pc       ds  int    expected
    vecs[0]  = '{1'b1, 5'd12, 32'h0000_FF01, 5'd12, 32'h0, 32'h0,   1'b0, 6'h00, 32'h0000_FF01};
    vecs[1]  = '{1'b1, 5'd14, 32'hDEAD_BEEC, 5'd14, 32'h0, 32'h0,   1'b0, 6'h00, 32'hDEAD_BEEC};
    vecs[2]  = '{1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0, 32'h0,   1'b0, 6'h00, 32'h00C0_0300};
    vecs[3]  = '{1'b1, 5'd13, 32'h0000_0000, 5'd13, 32'h0, 32'h0,   1'b0, 6'h2A, 32'h0000_A800};
    vecs[4]  = '{1'b0, 5'd0,  32'h0000_0000, 5'd13, 32'h0, 32'h0,   1'b0, 6'h00, 32'h0000_0000};
    vecs[5]  = '{1'b1, 5'd15, 32'h0000_0000, 5'd15, 32'h0, 32'h0,   1'b0, 6'h00, 32'h004C_0102};
    vecs[6]  = '{1'b1, 5'd16, 32'h0000_0000, 5'd16, 32'h0, 32'h0,   1'b0, 6'h00, 32'h0000_8000};
    vecs[7]  = '{1'b1, 5'd20, 32'h1234_5678, 5'd20, 32'h0, 32'h0,   1'b0, 6'h00, 32'h0000_0000};
    vecs[8]  = '{1'b1, 5'd9,  32'h0000_1234, 5'd9,  32'h0, 32'h0,   1'b0, 6'h00, 32'h0000_1234};
    vecs[9]  = '{1'b1, 5'd11, 32'h0000_0077, 5'd11, 32'h0, 32'h0,   1'b0, 6'h00, 32'h0000_0077};
    // syscall in delay slot
    vecs[10] = '{1'b0, 5'd0,  32'h0000_0000, 5'd14, 32'h8, 32'h100, 1'b1, 6'h00, 32'h0000_00FC};
    vecs[11] = '{1'b0, 5'd0,  32'h0000_0000, 5'd13, 32'h0, 32'h0,   1'b0, 6'h00, 32'h8000_0020};
    vecs[12] = '{1'b0, 5'd0,  32'h0000_0000, 5'd12, 32'h0, 32'h0,   1'b0, 6'h00, 32'h0000_FF03};
    // eret
    vecs[13] = '{1'b0, 5'd0,  32'h0000_0000, 5'd12, 32'he, 32'h0,   1'b0, 6'h00, 32'h0000_FF01};
    vecs[14] = '{1'b0, 5'd0,  32'h0000_0000, 5'd14, 32'h0, 32'h0,   1'b0, 6'h00, 32'h0000_00FC};
    // overflow with same-cycle EPC write
    vecs[15] = '{1'b1, 5'd14, 32'h0000_0040, 5'd14, 32'hc, 32'h200, 1'b0, 6'h00, 32'h0000_0200};
    vecs[16] = '{1'b0, 5'd0,  32'h0000_0000, 5'd13, 32'h0, 32'h0,   1'b0, 6'h00, 32'h0000_0030};
    // interrupt while EXL already set: EPC and BD held
    vecs[17] = '{1'b0, 5'd0,  32'h0000_0000, 5'd14, 32'h1, 32'h300, 1'b1, 6'h00, 32'h0000_0200};
    vecs[18] = '{1'b0, 5'd0,  32'h0000_0000, 5'd13, 32'h0, 32'h0,   1'b0, 6'h00, 32'h0000_0000};
    vecs[19] = '{1'b0, 5'd0,  32'h0000_0000, 5'd13, 32'h5, 32'h400, 1'b1, 6'h00, 32'h0000_0000};
    // RI with Status write clearing EXL: exception wins on EXL
    vecs[20] = '{1'b1, 5'd12, 32'h0000_0000, 5'd12, 32'ha, 32'h500, 1'b0, 6'h00, 32'h0000_0002};
    // trap with Cause write: both updates land, BD held under EXL
    vecs[21] = '{1'b1, 5'd13, 32'h00C0_0300, 5'd13, 32'hd, 32'h600, 1'b1, 6'h00, 32'h00C0_0334};

    // Reset state
    do_reset();
    rst = 1'b1;
    step();
    check_reset_state("reset");
    rst = 1'b0;

    // Table-driven register accesses and exceptions
    for (int i = 0; i < NVec; i++) begin
      we_i = vecs[i].we; waddr_i = vecs[i].waddr; data_i = vecs[i].wdata;
      raddr_i = vecs[i].raddr; excepttype_i = vecs[i].exc;
      current_inst_addr_i = vecs[i].pc; is_in_delayslot_i = vecs[i].ds; int_i = vecs[i].intr;
      step();
      idle_inputs();
      raddr_i = vecs[i].raddr;
      #1;
      check($sformatf("vec%0d", i), data_o, vecs[i].exp);
    end

    // Count wrap
    we_i = 1'b1; waddr_i = 5'd9; data_i = 32'hFFFF_FFFE;
    step();
    idle_inputs();
    check("wrap0", count_o, 32'hFFFF_FFFE);
    step();
    check("wrap1", count_o, 32'hFFFF_FFFF);
    step();
    check("wrap2", count_o, 32'h0000_0000);

    // Timer: Compare=5 right after reset
    do_reset();
    we_i = 1'b1; waddr_i = 5'd11; data_i = 32'd5;
    step();
    idle_inputs();
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (count_o == 32'd5) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("timer_reach5", {31'b0, found}, 32'h1);
    check("timer_pre", {31'b0, timer_int_o}, 32'h0);
    step();
    check("timer_set", {31'b0, timer_int_o}, 32'h1);
    step();
    check("timer_hold", {31'b0, timer_int_o}, 32'h1);
    we_i = 1'b1; waddr_i = 5'd11; data_i = 32'd9;
    step();
    idle_inputs();
    check("timer_clr", {31'b0, timer_int_o}, 32'h0);

    // Reset mid-count with a pending timer interrupt and competing updates
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (timer_int_o) begin
        found = 1'b1;
        break;
      end
    end
    check("timer_rearm", {31'b0, found}, 32'h1);
    rst = 1'b1;
    we_i = 1'b1; waddr_i = 5'd9; data_i = 32'h55;
    excepttype_i = 32'h8; current_inst_addr_i = 32'h700; is_in_delayslot_i = 1'b1;
    step();
    idle_inputs();
    check_reset_state("midrst");
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
